cache_req_arbiter: RTL and testbench
====================================

// Module: cache_req_arbiter
// PURPOSE
//   Two-requester round-robin arbiter in front of the single request port of
//   tt_um_cache_controller. Latches one requester's access, issues it with a
//   valid/ready handshake, waits for the cache response, and returns the data
//   to the owner with a one-cycle done pulse.
//   Only one transaction is outstanding at a time.
// PARAMETERS
//   ADDR_W   4   address width of requester and cache ports
//   DATA_W   8   data width of requester and cache ports
//   TMO_CYC  15  response timeout in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   rN_valid     in   1       requester N (N=0,1) access request; hold until rN_done
//   rN_we        in   1       requester N: 1=write, 0=read
//   rN_addr      in   ADDR_W  requester N address
//   rN_wdata     in   DATA_W  requester N write data
//   rN_done      out  1       one-cycle completion pulse to requester N
//   rN_rdata     out  DATA_W  read data; valid while rN_done=1
//   rN_err       out  1       timeout flag; valid while rN_done=1
//   c_valid      out  1       request to cache controller
//   c_we,c_addr,c_wdata  out  1/ADDR_W/DATA_W  latched request fields
//   c_ready      in   1       cache accepts the request when c_valid&c_ready
//   c_rsp_valid  in   1       cache response strobe
//   c_rdata      in   DATA_W  cache response data
//   busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0 (r0 favoured), all outputs and latches 0.
//   Reset mid-transaction aborts at once; c_valid drops asynchronously.
//   FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs are registered.
//   IDLE: sample r0_valid/r1_valid. If one is high, grant it. If both are
//     high, grant rr_ptr. Latch we/addr/wdata and owner. Go to ISSUE.
//     If neither is high, stay in IDLE.
//   ISSUE: c_valid=1 with latched fields. Hold until c_ready=1, then go to
//     WAIT. Fields never change while c_valid=1.
//   WAIT: on c_rsp_valid, latch c_rdata (writes also latch it; the value is
//     ignored) and go to RESP. c_rsp_valid in any other state is ignored.
//   RESP: owner's rN_done=1 for exactly 1 cycle with rN_rdata and rN_err.
//     The other requester's done stays 0. rr_ptr <= ~owner. Go to IDLE.
//   Minimum latency with c_ready=1 and a 1-cycle cache response:
//     valid@T0 -> c_valid@T1 -> rsp@T2 -> done@T3. Next grant @T4.
//   Requester protocol: drop rN_valid in the cycle after done. If valid is
//     still high, that is a new request.
//   A requester dropping valid mid-transaction does not abort it; done still
//     pulses.
//   rN_rdata holds its last value when done=0. rN_err=0 unless it was a timeout.
//   Fairness: with both requesters continuously valid, grants alternate
//     0,1,0,1...
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: a 4-bit counter clears on entry to ISSUE and
//     counts every cycle in ISSUE and WAIT.
//     When the count reaches TMO_CYC with no response, c_valid drops and the
//     FSM goes to RESP with rN_err=1 and rN_rdata=0.
//     A late c_rsp_valid arriving afterwards is ignored.
//   ARB_TIMEOUT_EN undefined: no counter; ISSUE/WAIT wait indefinitely;
//     rN_err is tied to 0.
// TESTING
//   1 Reset: rst=1 -> all outputs 0, busy=0. Release rst; no request ->
//     IDLE is held for 10 cycles.
//   2 r0 read addr=4'h3, c_ready=1, rsp 1 cycle later with c_rdata=8'hA5 ->
//     c_addr=3, c_we=0; r0_done@T3 with r0_rdata=A5; r1_done=0.
//   3 r0 and r1 valid together after reset for 4 transactions ->
//     grant order 0,1,0,1; each done pulses once.
//   4 r1 write addr=4'hF, wdata=8'h5A, c_ready low 3 cycles ->
//     c_valid high with stable fields for 4 cycles; r1_done after rsp.
//   5 rst pulse while in WAIT -> c_valid=0, busy=0 immediately.
//     A following c_rsp_valid produces no done.
//   6 (ARB_TIMEOUT_EN) c_ready=1, no rsp -> r0_done with r0_err=1 and
//     r0_rdata=0 after TMO_CYC cycles; a late rsp is ignored.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter
//   Two-requester round-robin arbiter in front of the single request port of
//   the cache controller. One transaction is outstanding at a time: the
//   winning requester's access is latched, issued with a valid/ready
//   handshake, the cache response is awaited, and the data is returned to the
//   owner with a one-cycle done pulse.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : a 4-bit counter runs through ISSUE and WAIT. After TMO_CYC
//                 cycles with no response the transaction completes with
//                 rN_err=1 and rN_rdata=0.
//     undefined : ISSUE/WAIT wait indefinitely, rN_err is always 0.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   rN_valid_i/we_i/addr_i/wdata_i   requester N access (hold until done)
//   rN_done_o                    one-cycle completion pulse to requester N
//   rN_rdata_o, rN_err_o         read data / timeout flag, valid with done
//   c_valid_o, c_we_o, c_addr_o, c_wdata_o   request to cache controller
//   c_ready_i                    cache accepts when c_valid_o & c_ready_i
//   c_rsp_valid_i, c_rdata_i     cache response strobe and data
//   busy_o                       high whenever the FSM is not in IDLE
//
// State table
//   S_IDLE  | sample requesters, grant one and latch its access
//   S_ISSUE | c_valid high with latched fields until c_ready
//   S_WAIT  | wait for the cache response strobe
//   S_RESP  | owner's done pulse; move round-robin pointer away from owner
// -----------------------------------------------------------------------------
module cache_req_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_valid_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_done_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r0_err_o,
    input  logic              r1_valid_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_done_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              r1_err_o,
    output logic              c_valid_o,
    output logic              c_we_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic [DATA_W-1:0] c_wdata_o,
    input  logic              c_ready_i,
    input  logic              c_rsp_valid_i,
    input  logic [DATA_W-1:0] c_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // The timeout counter is 4 bits wide; reject values it cannot reach.
    generate
        if (TMO_CYC < 1 || TMO_CYC > 15) begin : g_tmo_range
            $error("cache_req_arbiter: TMO_CYC must be in 1..15");
        end
    endgenerate

    state_t            state_q;
    logic              owner_q;
    logic              rr_ptr_q;
    logic              c_valid_q;
    logic              c_we_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [DATA_W-1:0] c_wdata_q;
    logic              busy_q;
    logic              r0_done_q;
    logic              r1_done_q;
    logic              r0_err_q;
    logic              r1_err_q;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;

    logic              grant_d;
    logic              fin_d;
    logic              fin_err_d;
    logic [DATA_W-1:0] fin_data_d;
    logic              tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);
    logic [3:0] tmo_cnt_q;

    // Zero in every cycle outside ISSUE/WAIT, so it is 0 on entry to ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Fires at the end of the TMO_CYC-th cycle spent in ISSUE/WAIT.
    assign tmo_hit = (state_q == S_ISSUE || state_q == S_WAIT) &&
                     (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        grant_d = 1'b0;
        if (r0_valid_i && r1_valid_i) begin
            grant_d = rr_ptr_q;
        end else if (r1_valid_i) begin
            grant_d = 1'b1;
        end

        // A real response in WAIT wins over a timeout in the same cycle.
        fin_d      = 1'b0;
        fin_err_d  = 1'b0;
        fin_data_d = c_rdata_i;
        if (state_q == S_WAIT && c_rsp_valid_i) begin
            fin_d = 1'b1;
        end else if (tmo_hit) begin
            fin_d      = 1'b1;
            fin_err_d  = 1'b1;
            fin_data_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            c_valid_q  <= 1'b0;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            c_wdata_q  <= '0;
            busy_q     <= 1'b0;
            r0_done_q  <= 1'b0;
            r1_done_q  <= 1'b0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            r0_done_q <= 1'b0;
            r1_done_q <= 1'b0;
            r0_err_q  <= 1'b0;
            r1_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (r0_valid_i || r1_valid_i) begin
                        owner_q   <= grant_d;
                        c_we_q    <= grant_d ? r1_we_i    : r0_we_i;
                        c_addr_q  <= grant_d ? r1_addr_i  : r0_addr_i;
                        c_wdata_q <= grant_d ? r1_wdata_i : r0_wdata_i;
                        c_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (fin_d) begin
                        // Timeout in ISSUE abandons the request, so drop c_valid.
                        c_valid_q <= 1'b0;
                        state_q   <= S_RESP;
                        if (owner_q) begin
                            r1_done_q  <= 1'b1;
                            r1_err_q   <= fin_err_d;
                            r1_rdata_q <= fin_data_d;
                        end else begin
                            r0_done_q  <= 1'b1;
                            r0_err_q   <= fin_err_d;
                            r0_rdata_q <= fin_data_d;
                        end
                    end else if (state_q == S_ISSUE && c_ready_i) begin
                        c_valid_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_RESP: begin
                    rr_ptr_q <= ~owner_q;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign r0_done_o  = r0_done_q;
    assign r0_rdata_o = r0_rdata_q;
    assign r0_err_o   = r0_err_q;
    assign r1_done_o  = r1_done_q;
    assign r1_rdata_o = r1_rdata_q;
    assign r1_err_o   = r1_err_q;
    assign c_valid_o  = c_valid_q;
    assign c_we_o     = c_we_q;
    assign c_addr_o   = c_addr_q;
    assign c_wdata_o  = c_wdata_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

    localparam int TMO_CYC = 15;
    localparam int NV      = 37;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r0_we, r1_valid, r1_we;
    logic [3:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_done, r0_err, r1_done, r1_err;
    logic [7:0] r0_rdata, r1_rdata;
    logic       c_valid, c_we, c_ready, c_rsp_valid, busy;
    logic [3:0] c_addr;
    logic [7:0] c_wdata, c_rdata;

    cache_req_arbiter #(.ADDR_W(4), .DATA_W(8), .TMO_CYC(TMO_CYC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .r0_valid_i    (r0_valid),
        .r0_we_i       (r0_we),
        .r0_addr_i     (r0_addr),
        .r0_wdata_i    (r0_wdata),
        .r0_done_o     (r0_done),
        .r0_rdata_o    (r0_rdata),
        .r0_err_o      (r0_err),
        .r1_valid_i    (r1_valid),
        .r1_we_i       (r1_we),
        .r1_addr_i     (r1_addr),
        .r1_wdata_i    (r1_wdata),
        .r1_done_o     (r1_done),
        .r1_rdata_o    (r1_rdata),
        .r1_err_o      (r1_err),
        .c_valid_o     (c_valid),
        .c_we_o        (c_we),
        .c_addr_o      (c_addr),
        .c_wdata_o     (c_wdata),
        .c_ready_i     (c_ready),
        .c_rsp_valid_i (c_rsp_valid),
        .c_rdata_i     (c_rdata),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // ctl  = {rst, r0_valid, r0_we, r1_valid, r1_we, c_ready, c_rsp_valid}
    // eflg = {r0_done, r0_err, r1_done, r1_err, c_valid, c_we, busy}
    typedef struct packed {
        logic [6:0] ctl;
        logic [3:0] r0a;
        logic [7:0] r0d;
        logic [3:0] r1a;
        logic [7:0] r1d;
        logic [7:0] crd;
        logic [6:0] eflg;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic [3:0] ca;
        logic [7:0] cd;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [34:0] outs();
        return {r0_done, r0_err, r1_done, r1_err, c_valid, c_we, busy,
                r0_rdata, r1_rdata, c_addr, c_wdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        logic seen;
        logic cv_ok;

        // Single r0 read of 3 returning A5, then release.
        vecs[0]  = '{7'b1000000, 4'h3, 8'h00, 4'h0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 4'h0, 8'h00};
        vecs[1]  = '{7'b0100010, 4'h3, 8'h00, 4'h0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 4'h0, 8'h00};
        vecs[2]  = '{7'b0100010, 4'h3, 8'h00, 4'h0, 8'h00, 8'h00, 7'b0000101, 8'h00, 8'h00, 4'h3, 8'h00};
        vecs[3]  = '{7'b0100011, 4'h3, 8'h00, 4'h0, 8'h00, 8'hA5, 7'b0000001, 8'h00, 8'h00, 4'h3, 8'h00};
        vecs[4]  = '{7'b0100010, 4'h3, 8'h00, 4'h0, 8'h00, 8'h00, 7'b1000001, 8'hA5, 8'h00, 4'h3, 8'h00};
        vecs[5]  = '{7'b0000010, 4'h3, 8'h00, 4'h0, 8'h00, 8'h00, 7'b0000000, 8'hA5, 8'h00, 4'h3, 8'h00};
        // Both requesters valid from reset: grants 0,1,0,1.
        vecs[6]  = '{7'b1101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000000, 8'h00, 8'h00, 4'h0, 8'h00};
        vecs[7]  = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000000, 8'h00, 8'h00, 4'h0, 8'h00};
        vecs[8]  = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000101, 8'h00, 8'h00, 4'h1, 8'h00};
        vecs[9]  = '{7'b0101111, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h11, 7'b0000001, 8'h00, 8'h00, 4'h1, 8'h00};
        vecs[10] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b1000001, 8'h11, 8'h00, 4'h1, 8'h00};
        vecs[11] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000000, 8'h11, 8'h00, 4'h1, 8'h00};
        vecs[12] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000111, 8'h11, 8'h00, 4'h2, 8'h3C};
        vecs[13] = '{7'b0101111, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h22, 7'b0000011, 8'h11, 8'h00, 4'h2, 8'h3C};
        vecs[14] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0010011, 8'h11, 8'h22, 4'h2, 8'h3C};
        vecs[15] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000010, 8'h11, 8'h22, 4'h2, 8'h3C};
        vecs[16] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000101, 8'h11, 8'h22, 4'h1, 8'h00};
        vecs[17] = '{7'b0101111, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h33, 7'b0000001, 8'h11, 8'h22, 4'h1, 8'h00};
        vecs[18] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b1000001, 8'h33, 8'h22, 4'h1, 8'h00};
        vecs[19] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000000, 8'h33, 8'h22, 4'h1, 8'h00};
        vecs[20] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000111, 8'h33, 8'h22, 4'h2, 8'h3C};
        vecs[21] = '{7'b0101111, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h44, 7'b0000011, 8'h33, 8'h22, 4'h2, 8'h3C};
        vecs[22] = '{7'b0101110, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0010011, 8'h33, 8'h44, 4'h2, 8'h3C};
        vecs[23] = '{7'b0000010, 4'h1, 8'h00, 4'h2, 8'h3C, 8'h00, 7'b0000010, 8'h33, 8'h44, 4'h2, 8'h3C};
        // r1 write F/5A with c_ready low 3 cycles; r1 drops valid early,
        // a stray rsp in ISSUE and an r0 request arriving mid-transaction.
        vecs[24] = '{7'b0001100, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000010, 8'h33, 8'h44, 4'h2, 8'h3C};
        vecs[25] = '{7'b0000001, 4'h7, 8'h00, 4'hF, 8'h5A, 8'hEE, 7'b0000111, 8'h33, 8'h44, 4'hF, 8'h5A};
        vecs[26] = '{7'b0100000, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000111, 8'h33, 8'h44, 4'hF, 8'h5A};
        vecs[27] = '{7'b0100000, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000111, 8'h33, 8'h44, 4'hF, 8'h5A};
        vecs[28] = '{7'b0100010, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000111, 8'h33, 8'h44, 4'hF, 8'h5A};
        vecs[29] = '{7'b0100011, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h77, 7'b0000011, 8'h33, 8'h44, 4'hF, 8'h5A};
        vecs[30] = '{7'b0100010, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0010011, 8'h33, 8'h77, 4'hF, 8'h5A};
        vecs[31] = '{7'b0100010, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000010, 8'h33, 8'h77, 4'hF, 8'h5A};
        vecs[32] = '{7'b0100010, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000101, 8'h33, 8'h77, 4'h7, 8'h00};
        vecs[33] = '{7'b0100011, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h88, 7'b0000001, 8'h33, 8'h77, 4'h7, 8'h00};
        vecs[34] = '{7'b0100010, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b1000001, 8'h88, 8'h77, 4'h7, 8'h00};
        vecs[35] = '{7'b0000011, 4'h7, 8'h00, 4'hF, 8'h5A, 8'hFF, 7'b0000000, 8'h88, 8'h77, 4'h7, 8'h00};
        vecs[36] = '{7'b0000000, 4'h7, 8'h00, 4'hF, 8'h5A, 8'h00, 7'b0000000, 8'h88, 8'h77, 4'h7, 8'h00};

        rst = 1'b1;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 4'h0; r0_wdata = 8'h00;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 4'h0; r1_wdata = 8'h00;
        c_ready = 1'b0; c_rsp_valid = 1'b0; c_rdata = 8'h00;

        // Reset values and idle hold.
        tick();
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold", 64'({busy, c_valid, r0_done, r1_done}), 64'd0);
        end

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            {rst, r0_valid, r0_we, r1_valid, r1_we, c_ready, c_rsp_valid} = vecs[i].ctl;
            r0_addr  = vecs[i].r0a;
            r0_wdata = vecs[i].r0d;
            r1_addr  = vecs[i].r1a;
            r1_wdata = vecs[i].r1d;
            c_rdata  = vecs[i].crd;
            #4;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].eflg, vecs[i].rd0, vecs[i].rd1, vecs[i].ca, vecs[i].cd}));
        end

        // Asynchronous reset while in ISSUE and while in WAIT.
        r0_addr = 4'h9; r0_valid = 1'b1; c_ready = 1'b0;
        tick();
        chk("rst_issue_pre", 64'({c_valid, busy}), 64'(2'b11));
        r0_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_issue_async", 64'({c_valid, busy}), 64'd0);
        tick();
        rst = 1'b0;
        r0_valid = 1'b1; c_ready = 1'b1;
        tick();
        tick();
        r0_valid = 1'b0;
        chk("rst_wait_pre", 64'({c_valid, busy}), 64'(2'b01));
        rst = 1'b1;
        #1;
        chk("rst_wait_async", 64'(outs()), 64'd0);
        tick();
        rst = 1'b0; c_rsp_valid = 1'b1; c_rdata = 8'hEE;
        tick();
        seen = r0_done | r1_done | busy;
        c_rsp_valid = 1'b0;
        repeat (2) begin
            tick();
            seen = seen | r0_done | r1_done | busy;
        end
        chk("rst_late_rsp", 64'({seen, r0_rdata, r1_rdata}), 64'd0);

        // Normal r0 read returning AB so rdata is non-zero before the next part.
        r0_addr = 4'h5; r0_valid = 1'b1; c_ready = 1'b1;
        tick();
        tick();
        c_rsp_valid = 1'b1; c_rdata = 8'hAB;
        tick();
        c_rsp_valid = 1'b0; r0_valid = 1'b0;
        chk("pre_txn", 64'({r0_done, r0_err, r0_rdata}), 64'({1'b1, 1'b0, 8'hAB}));
        tick();

`ifdef ARB_TIMEOUT_EN
        r0_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (r0_done) break;
        end
        chk("tmo_latency", 64'(n), 64'(TMO_CYC + 1));
        chk("tmo_result", 64'({r0_done, r0_err, r0_rdata, r1_done, r1_err, c_valid}),
            64'({1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
        r0_valid = 1'b0;
        tick();
        c_rsp_valid = 1'b1; c_rdata = 8'hCD;
        tick();
        seen = r0_done | r1_done | busy;
        c_rsp_valid = 1'b0;
        tick();
        seen = seen | r0_done | r1_done | busy;
        chk("tmo_late_rsp", 64'({seen, r0_rdata}), 64'd0);

        // Timeout while still in ISSUE: c_valid held until the timeout drops it.
        c_ready = 1'b0; r0_valid = 1'b1;
        n = 0; cv_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (r0_done) break;
            if (!c_valid) cv_ok = 1'b0;
        end
        chk("tmo_issue", 64'({n[7:0], c_valid, r0_err, cv_ok}),
            64'({8'(TMO_CYC + 1), 1'b0, 1'b1, 1'b1}));
        r0_valid = 1'b0; c_ready = 1'b1;
        tick();
`else
        r0_valid = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | r0_done | r0_err | r1_done;
        end
        chk("no_tmo_wait", 64'({seen, busy}), 64'(2'b01));
        c_rsp_valid = 1'b1; c_rdata = 8'hCD;
        tick();
        c_rsp_valid = 1'b0; r0_valid = 1'b0;
        chk("no_tmo_rsp", 64'({r0_done, r0_err, r0_rdata}), 64'({1'b1, 1'b0, 8'hCD}));
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
